pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: max consecutive MEM_WAIT cycles before error.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs, id_rt  input  5 each  ID-stage source registers.
REQ-005 SHALL have port id_uses_rt  input  1  ID instruction reads rt.
REQ-006 SHALL have ports ex_memread  input  1, ex_rt  input  5  EX-stage load and its destination.
REQ-007 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-008 SHALL have ports mem_req  input  1, mem_ready  input  1  MEM-stage data-memory handshake.
REQ-009 SHALL have ports pc_we, ifid_we, idex_we, exmem_we  output  1 each  stage-register write enables.
REQ-010 SHALL have ports ifid_flush, idex_flush, memwb_bubble  output  1 each  zero the next stage register.
REQ-011 SHALL have ports err  output  1 (sticky timeout), stall_cnt  output  16 (frozen-PC cycle count).

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, ERROR; state, wait_cnt (8-bit) and stall_cnt registered on clk.
REQ-013 SHALL define mem_busy = mem_req & ~mem_ready; load_use = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
REQ-014 SHALL drive outputs combinationally from state and current inputs, priority: ERROR > mem_busy > ex_branch_taken > load_use > normal.
REQ-015 Normal: all *_we = 1, all flush/bubble = 0.
REQ-016 mem_busy (RUN or MEM_WAIT): all *_we = 0, memwb_bubble = 1, flushes = 0.
REQ-017 ex_branch_taken, not mem_busy: all *_we = 1, ifid_flush = 1, idex_flush = 1.
REQ-018 load_use, no higher condition: pc_we = 0, ifid_we = 0, idex_we = 1, exmem_we = 1, idex_flush = 1 (one bubble per cycle of hazard).
REQ-019 Branch-taken and load_use together SHALL resolve as branch only (load_use ignored, no stall).
REQ-020 RUN -> MEM_WAIT when mem_busy; wait_cnt loads 1.
REQ-021 MEM_WAIT: mem_ready = 1 -> outputs per REQ-014 without mem_busy term that cycle, next state RUN, wait_cnt cleared.
REQ-022 MEM_WAIT: mem_busy and wait_cnt == TIMEOUT -> next state ERROR; otherwise wait_cnt increments.
REQ-023 MEM_WAIT with mem_req dropped SHALL be treated as mem_ready = 1.
REQ-024 ERROR: all *_we = 0, all flush/bubble = 0, err = 1; exit only by reset.
REQ-025 stall_cnt SHALL increment on each clock edge where pc_we = 0 (including ERROR), wrapping 16'hFFFF -> 0.
REQ-026 err SHALL be registered, equal to (state == ERROR).

Reset
REQ-027 reset low SHALL immediately force state = RUN, wait_cnt = 0, stall_cnt = 0, err = 0, regardless of clk.
REQ-028 During reset outputs SHALL follow REQ-014 from RUN (err = 0); reset mid-MEM_WAIT or in ERROR returns to RUN with counters zero.
REQ-029 First clk edge after reset release SHALL sample inputs normally.

Verification
REQ-030 Load-use: ex_memread=1, ex_rt=5, id_rs=5 one cycle -> pc_we=0, ifid_we=0, idex_flush=1, stall_cnt 0->1; ex_rt=0 same case -> no stall.
REQ-031 Branch+load-use same cycle: ex_branch_taken=1, load_use=1 -> all we=1, ifid_flush=idex_flush=1, stall_cnt unchanged.
REQ-032 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles all we=0, memwb_bubble=1, state MEM_WAIT; 4th cycle all we=1, RUN next, stall_cnt=3.
REQ-033 Timeout: TIMEOUT=4, mem_ready held 0 -> ERROR entered after 5th busy cycle, err=1, all we=0 thereafter; mem_ready=1 does not clear.
REQ-034 Async reset in ERROR: reset low between clk edges -> err=0, stall_cnt=0 immediately; normal enables after release.
REQ-035 stall_cnt wrap: preload by 65535 load-use cycles, one more -> stall_cnt = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard controller (load-use stall, branch flush, MEM-stage wait with timeout).
// Latency: enables/flushes are combinational from state + inputs; err and stall_cnt are registered.
// Backpressure: a busy data memory freezes every stage register and bubbles MEM/WB until mem_ready.
// Ports: clk/reset (async active-low); ID/EX/MEM hazard inputs; stage write enables,
//        flush/bubble controls, sticky err and the 16-bit frozen-PC cycle counter.
module pipe_hazard_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        err_q, err_d;

    logic mem_busy;
    logic load_use;

    // A dropped mem_req in MEM_WAIT reads as "not busy", i.e. the same as mem_ready.
    assign mem_busy = mem_req & ~mem_ready;
    assign load_use = ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // Stage controls, priority: ERROR > mem_busy > branch > load_use > normal.
    // A taken branch squashes the dependent ID instruction, so load_use is moot.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (state_q == ERROR) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (mem_busy) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
        stall_cnt_d = pc_we ? stall_cnt_q : stall_cnt_q + 16'd1;
        // err tracks the next state so it is high exactly while state_q is ERROR.
        err_d       = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: scenario-driven scoreboard bench for pipe_hazard_ctrl (TIMEOUT = 4).
// Latency: expected enables checked mid-cycle; stall_cnt/err checked 1 time unit after the edge.
// Backpressure: none from the bench; every wait is a fixed number of clock edges.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
    logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble, err;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .err(err), .stall_cnt(stall_cnt)
    );

    // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [6:0] NORM = 7'b1111_000;
    localparam logic [6:0] BUSY = 7'b0000_001;
    localparam logic [6:0] BR   = 7'b1111_110;
    localparam logic [6:0] LU   = 7'b0011_010;
    localparam logic [6:0] ERRO = 7'b0000_000;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        uses, mrd;
        logic [4:0]  ert;
        logic        br, req, rdy;
        logic [6:0]  outs;
        logic [15:0] stall;
        logic        err;
    } stim_t;

    stim_t sb[$];
    int ncmp = 0;
    int nfail = 0;

    function automatic logic [6:0] obs();
        return {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                 input logic mrd, input logic [4:0] ert, input logic br,
                                 input logic req, input logic rdy, input logic [6:0] outs,
                                 input logic [15:0] stall, input logic e);
        stim_t s;
        s.rs = rs; s.rt = rt; s.uses = uses; s.mrd = mrd; s.ert = ert;
        s.br = br; s.req = req; s.rdy = rdy; s.outs = outs; s.stall = stall; s.err = e;
        return s;
    endfunction

    // Drives one cycle of stimulus at the falling edge and queues what it should produce.
    task automatic drive(input stim_t s);
        @(negedge clk);
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses; ex_memread = s.mrd; ex_rt = s.ert;
        ex_branch_taken = s.br; mem_req = s.req; mem_ready = s.rdy;
        sb.push_back(s);
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stim_t e;
        reset = 1'b0;
        idle_inputs();
        #3;
        ncmp++; if (obs() !== NORM) begin nfail++; $display("FAIL reset_outs got=%b exp=%b", obs(), NORM); end
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        ncmp++; if (err !== 1'b0) begin nfail++; $display("FAIL reset_err got=%b exp=0", err); end
        // Outputs still decode from RUN while reset is held.
        mem_req = 1'b1;
        #1;
        ncmp++; if (obs() !== BUSY) begin nfail++; $display("FAIL reset_busy_outs got=%b exp=%b", obs(), BUSY); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        drive(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU, 16'd1, 1'b0));
        #2; e = sb.pop_front();
        ncmp++; if (obs() !== e.outs) begin nfail++; $display("FAIL post_reset_outs got=%b exp=%b", obs(), e.outs); end
        @(posedge clk); #1;
        ncmp++; if (stall_cnt !== e.stall) begin nfail++; $display("FAIL post_reset_stall got=%0d exp=%0d", stall_cnt, e.stall); end
    endtask

    task automatic test_load_use();
        stim_t v[$];
        stim_t e;
        do_reset();
        v.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU,   16'd1, 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 16'd1, 1'b0));
        v.push_back(mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, LU,   16'd2, 1'b0));
        v.push_back(mk(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NORM, 16'd2, 1'b0));
        v.push_back(mk(5'd5, 5'd6, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, NORM, 16'd2, 1'b0));
        v.push_back(mk(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU,   16'd3, 1'b0));
        v.push_back(mk(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU,   16'd4, 1'b0));
        foreach (v[i]) begin
            drive(v[i]);
            #2; e = sb.pop_front();
            ncmp++; if (obs() !== e.outs) begin nfail++; $display("FAIL load_use[%0d] outs got=%b exp=%b", i, obs(), e.outs); end
            @(posedge clk); #1;
            ncmp++; if (stall_cnt !== e.stall) begin nfail++; $display("FAIL load_use[%0d] stall got=%0d exp=%0d", i, stall_cnt, e.stall); end
        end
    endtask

    task automatic test_branch();
        stim_t v[$];
        stim_t e;
        do_reset();
        v.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, BR,   16'd0, 1'b0));
        v.push_back(mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, BR,   16'd0, 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, BUSY, 16'd1, 1'b0));
        // mem_req dropped while waiting counts as ready.
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, BR,   16'd1, 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 16'd1, 1'b0));
        foreach (v[i]) begin
            drive(v[i]);
            #2; e = sb.pop_front();
            ncmp++; if (obs() !== e.outs) begin nfail++; $display("FAIL branch[%0d] outs got=%b exp=%b", i, obs(), e.outs); end
            @(posedge clk); #1;
            ncmp++; if (stall_cnt !== e.stall) begin nfail++; $display("FAIL branch[%0d] stall got=%0d exp=%0d", i, stall_cnt, e.stall); end
        end
    endtask

    task automatic test_mem_wait();
        stim_t v[$];
        stim_t e;
        do_reset();
        for (int k = 1; k <= 3; k++)
            v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BUSY, 16'(k), 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, 16'd3, 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 16'd3, 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BUSY, 16'd4, 1'b0));
        // Ready cycle in MEM_WAIT still honours a load-use hazard.
        v.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, LU,   16'd5, 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 16'd5, 1'b0));
        foreach (v[i]) begin
            drive(v[i]);
            #2; e = sb.pop_front();
            ncmp++; if (obs() !== e.outs) begin nfail++; $display("FAIL mem_wait[%0d] outs got=%b exp=%b", i, obs(), e.outs); end
            @(posedge clk); #1;
            ncmp++; if (stall_cnt !== e.stall) begin nfail++; $display("FAIL mem_wait[%0d] stall got=%0d exp=%0d", i, stall_cnt, e.stall); end
            ncmp++; if (err !== e.err) begin nfail++; $display("FAIL mem_wait[%0d] err got=%b exp=%b", i, err, e.err); end
        end
    endtask

    task automatic test_timeout();
        stim_t v[$];
        stim_t e;
        do_reset();
        // Four busy cycles stays one short of the limit.
        for (int k = 1; k <= 4; k++)
            v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BUSY, 16'(k), 1'b0));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, 16'd4, 1'b0));
        // Five busy cycles: ERROR after the fifth edge.
        for (int k = 1; k <= 5; k++)
            v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BUSY, 16'(4 + k), (k == 5)));
        v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ERRO, 16'd10, 1'b1));
        v.push_back(mk(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, ERRO, 16'd11, 1'b1));
        foreach (v[i]) begin
            drive(v[i]);
            #2; e = sb.pop_front();
            ncmp++; if (obs() !== e.outs) begin nfail++; $display("FAIL timeout[%0d] outs got=%b exp=%b", i, obs(), e.outs); end
            @(posedge clk); #1;
            ncmp++; if (stall_cnt !== e.stall) begin nfail++; $display("FAIL timeout[%0d] stall got=%0d exp=%0d", i, stall_cnt, e.stall); end
            ncmp++; if (err !== e.err) begin nfail++; $display("FAIL timeout[%0d] err got=%b exp=%b", i, err, e.err); end
        end
    endtask

    // Runs straight after test_timeout, so the DUT starts in ERROR.
    task automatic test_async_reset();
        stim_t e;
        @(negedge clk);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        ncmp++; if (err !== 1'b0) begin nfail++; $display("FAIL async_err got=%b exp=0", err); end
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL async_stall got=%0d exp=0", stall_cnt); end
        ncmp++; if (obs() !== NORM) begin nfail++; $display("FAIL async_outs got=%b exp=%b", obs(), NORM); end
        @(posedge clk); #1;
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL async_hold_stall got=%0d exp=0", stall_cnt); end
        @(negedge clk);
        reset = 1'b1;
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 16'd0, 1'b0));
        #2; e = sb.pop_front();
        ncmp++; if (obs() !== e.outs) begin nfail++; $display("FAIL async_release_outs got=%b exp=%b", obs(), e.outs); end
        @(posedge clk); #1;
        ncmp++; if (err !== e.err) begin nfail++; $display("FAIL async_release_err got=%b exp=%b", err, e.err); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
        repeat (65535) @(posedge clk);
        #1;
        ncmp++; if (stall_cnt !== 16'hFFFF) begin nfail++; $display("FAIL wrap_preload got=%h exp=ffff", stall_cnt); end
        ncmp++; if (obs() !== LU) begin nfail++; $display("FAIL wrap_outs got=%b exp=%b", obs(), LU); end
        @(posedge clk); #1;
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL wrap_zero got=%h exp=0000", stall_cnt); end
        ncmp++; if (err !== 1'b0) begin nfail++; $display("FAIL wrap_err got=%b exp=0", err); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
